counter_ctrl: RTL and testbench

//  Front-panel control stage sitting directly upstream of universal_counter.

---
 rtl/counter_ctrl.sv | 118 +++++++++++
 tb/tb_counter_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - button synchronise/debounce front end and run/pause/clear FSM
// Drives universal_counter clear/mode/incr/pause from registered outputs.
module counter_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 3
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       btn_run,
    input  logic       btn_dir,
    input  logic       btn_mode,
    input  logic       btn_clr,
    output logic       clear,
    output logic       mode,
    output logic       incr,
    output logic       pause,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_CLR   = 2'b11
    } state_t;

    localparam int BTN_RUN  = 0;
    localparam int BTN_DIR  = 1;
    localparam int BTN_MODE = 2;
    localparam int BTN_CLR  = 3;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [3:0]            btn_raw;
    logic [3:0]            sync1_q, sync2_q;
    logic [3:0]            level_q, level_d, level_dly_q;
    logic [3:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [3:0]            press;

    state_t state_q;
    logic   clear_q, pause_q, incr_q, mode_q;

    assign btn_raw = {btn_clr, btn_mode, btn_dir, btn_run};
    assign press   = level_q & ~level_dly_q;

    // Counter tracks consecutive disagreeing samples; the level only moves on the DB_CYCLES-th.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                level_d[i]  = ~level_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            db_cnt_q    <= '0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            db_cnt_q    <= db_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
            clear_q <= 1'b0;
            pause_q <= 1'b1;
            incr_q  <= 1'b1;
            mode_q  <= 1'b0;
        end else if (state_q == S_CLR) begin
            state_q <= S_IDLE;
            clear_q <= 1'b0;
            pause_q <= 1'b1;
        end else if (press[BTN_CLR]) begin
            state_q <= S_CLR;
            clear_q <= 1'b1;
            pause_q <= 1'b1;
        end else begin
            if (press[BTN_DIR]) begin
                incr_q <= ~incr_q;
            end
            // Mode is only changeable while the counter is held (pre-edge state).
            if (press[BTN_MODE] && (state_q != S_RUN)) begin
                mode_q <= ~mode_q;
            end
            if (press[BTN_RUN]) begin
                if (state_q == S_RUN) begin
                    state_q <= S_PAUSE;
                    pause_q <= 1'b1;
                end else begin
                    state_q <= S_RUN;
                    pause_q <= 1'b0;
                end
            end
        end
    end

    assign clear = clear_q;
    assign pause = pause_q;
    assign incr  = incr_q;
    assign mode  = mode_q;
    assign state = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - self-checking bench for counter_ctrl
module tb_counter_ctrl;

    localparam int DB = 4;
    localparam logic [5:0] RST_O = 6'b00_0_1_1_0;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       btn_run, btn_dir, btn_mode, btn_clr;
    logic       clear, mode, incr, pause;
    logic [1:0] state;
    logic [5:0] dut_o;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    counter_ctrl #(.DB_CYCLES(DB), .DB_W(3)) dut (
        .clk(clk), .clear_n(clear_n),
        .btn_run(btn_run), .btn_dir(btn_dir), .btn_mode(btn_mode), .btn_clr(btn_clr),
        .clear(clear), .mode(mode), .incr(incr), .pause(pause), .state(state)
    );

    assign dut_o = {state, clear, pause, incr, mode};

    // Reference model: raw sample history per button, debounced level flips when the
    // last DB synchronised samples (raw delayed by two edges) all disagree with it.
    logic [15:0] rawv [4] = '{default: '0};
    logic [3:0]  m_lvl = '0, m_lvl_old = '0;
    logic [1:0]  m_state = 2'b00;
    logic        m_clear = 1'b0, m_pause = 1'b1, m_incr = 1'b1, m_mode = 1'b0;

    function automatic bit window_flip(input logic [15:0] h, input logic lv);
        for (int j = 0; j < DB; j++)
            if (h[2+j] == lv) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge clear_n) begin
        logic [3:0] raw, prs;
        if (!clear_n) begin
            for (int b = 0; b < 4; b++) rawv[b] = '0;
            m_lvl = '0; m_lvl_old = '0;
            m_state = 2'b00; m_clear = 1'b0; m_pause = 1'b1; m_incr = 1'b1; m_mode = 1'b0;
        end else begin
            raw = {btn_clr, btn_mode, btn_dir, btn_run};
            prs = m_lvl & ~m_lvl_old;
            if (m_state == 2'b11) begin
                m_state = 2'b00; m_clear = 1'b0; m_pause = 1'b1;
            end else if (prs[3]) begin
                m_state = 2'b11; m_clear = 1'b1; m_pause = 1'b1;
            end else begin
                if (prs[1]) m_incr = !m_incr;
                if (prs[2] && m_pause) m_mode = !m_mode;
                if (prs[0]) begin
                    m_state = (m_state == 2'b01) ? 2'b10 : 2'b01;
                    m_pause = (m_state != 2'b01);
                end
            end
            m_lvl_old = m_lvl;
            for (int b = 0; b < 4; b++) begin
                rawv[b] = {rawv[b][14:0], raw[b]};
                if (window_flip(rawv[b], m_lvl[b])) m_lvl[b] = ~m_lvl[b];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (dut_o !== {m_state, m_clear, m_pause, m_incr, m_mode}) begin
                failures++;
                $display("FAIL model t=%0t got=%b exp=%b", $time, dut_o,
                         {m_state, m_clear, m_pause, m_incr, m_mode});
            end
        end
    end

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input logic [3:0] b);
        {btn_clr, btn_mode, btn_dir, btn_run} = b;
    endtask

    task automatic press(input logic [3:0] b, input int hold);
        set_btn(b);
        tick(hold);
        set_btn(4'b0000);
        tick(12);
    endtask

    task automatic wait_clear(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (clear === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for clear got=%b exp=1", name, clear);
        end
    endtask

    typedef struct {
        logic [3:0] btn;    // {clr, mode, dir, run}
        int         hold;
        logic [5:0] exp;    // {state, clear, pause, incr, mode}
    } vec_t;

    vec_t vecs [12];

    initial begin
        bit ok;
        logic saved_incr;

        // state, clear, pause, incr, mode -- table starts in RUN
        vecs[0]  = '{4'b0100, 10, 6'b01_0_0_1_0};  // mode ignored in RUN
        vecs[1]  = '{4'b0010,  3, 6'b01_0_0_1_0};  // 3-sample glitch rejected
        vecs[2]  = '{4'b0010,  4, 6'b01_0_0_0_0};  // 4 samples accepted
        vecs[3]  = '{4'b0010, 10, 6'b01_0_0_1_0};
        vecs[4]  = '{4'b0001, 10, 6'b10_0_1_1_0};  // RUN -> PAUSE
        vecs[5]  = '{4'b0100, 10, 6'b10_0_1_1_1};  // mode in PAUSE
        vecs[6]  = '{4'b0011, 10, 6'b01_0_0_0_1};  // run + dir together
        vecs[7]  = '{4'b0001,  3, 6'b01_0_0_0_1};
        vecs[8]  = '{4'b1000, 10, 6'b00_0_1_0_1};  // clear keeps incr/mode
        vecs[9]  = '{4'b0101, 10, 6'b01_0_0_0_0};  // mode uses pre-edge IDLE
        vecs[10] = '{4'b0110, 10, 6'b01_0_0_1_0};  // dir applies, mode gated
        vecs[11] = '{4'b1001, 10, 6'b00_0_1_1_0};  // clr beats run

        clear_n = 1'b0;
        set_btn(4'b0000);
        #20;
        chk("reset_20ns", dut_o, RST_O);
        chk_en = 1'b1;
        tick(100);
        chk("reset_hold100", dut_o, RST_O);
        clear_n = 1'b1;
        tick(3);

        // first-press latency: outputs change exactly after edge DB+2
        set_btn(4'b0001);
        for (int e = 0; e <= DB + 2; e++) begin
            @(negedge clk);
            chk($sformatf("latency_edge%0d", e), dut_o,
                (e < DB + 2) ? 6'b00_0_1_1_0 : 6'b01_0_0_1_0);
        end
        tick(3);
        set_btn(4'b0000);
        tick(12);

        for (int i = 0; i < 12; i++) begin
            press(vecs[i].btn, vecs[i].hold);
            chk($sformatf("vec%0d", i), dut_o, vecs[i].exp);
        end

        // clear priority: one CLR cycle then IDLE
        press(4'b0001, 10);
        chk("prio_in_run", dut_o[5:4], 2'b01);
        set_btn(4'b1001);
        wait_clear("prio", ok);
        if (ok) begin
            chk("prio_clr_cycle", dut_o, {2'b11, 1'b1, 1'b1, incr, mode});
            @(negedge clk);
            chk("prio_after_clr", {state, clear, pause}, 4'b00_0_1);
        end
        tick(8);
        set_btn(4'b0000);
        tick(12);
        chk("prio_no_repeat", {state, clear, pause}, 4'b00_0_1);

        // holding a button toggles once only
        saved_incr = incr;
        set_btn(4'b0010);
        tick(30);
        chk("hold_once", {5'b0, incr}, {5'b0, ~saved_incr});
        set_btn(4'b0000);
        tick(12);
        chk("hold_release", {5'b0, incr}, {5'b0, ~saved_incr});

        // reset in the middle of a debounce count
        set_btn(4'b0001);
        tick(DB + 1);
        #1 clear_n = 1'b0;
        set_btn(4'b0000);
        #1 chk("rst_mid_db", dut_o, RST_O);
        @(negedge clk);
        clear_n = 1'b1;
        tick(12);
        chk("rst_mid_db_after", dut_o, RST_O);

        // reset while in CLR
        set_btn(4'b1000);
        wait_clear("rst_clr", ok);
        if (ok) begin
            #1 clear_n = 1'b0;
            set_btn(4'b0000);
            #1 chk("rst_mid_clr", dut_o, RST_O);
            @(negedge clk);
            clear_n = 1'b1;
        end
        set_btn(4'b0000);
        tick(12);
        chk("rst_mid_clr_after", dut_o, RST_O);

        // random button chatter against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0)  btn_run  = ~btn_run;
            if ($urandom_range(0, 7) == 0)  btn_dir  = ~btn_dir;
            if ($urandom_range(0, 7) == 0)  btn_mode = ~btn_mode;
            if ($urandom_range(0, 23) == 0) btn_clr  = ~btn_clr;
        end
        set_btn(4'b0000);
        tick(12);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
